// File: rtl/dev_timer_pkg.sv
// dev_timer_pkg
//   Shared definitions for the memory-mapped interval timer:
//   register byte offsets, CTRL bit positions and the CTRL register layout.
//   Optional build macro: DEV_TIMER_CAPTURE_EN (adds the CAPTURE register).
package dev_timer_pkg;

    // Register byte offsets (address bits [1:0] are ignored by the decoder)
    localparam logic [31:0] OFF_CTRL     = 32'h0000_0000;
    localparam logic [31:0] OFF_COUNT    = 32'h0000_0004;
    localparam logic [31:0] OFF_COMPARE  = 32'h0000_0008;
    localparam logic [31:0] OFF_PRESCALE = 32'h0000_000C;
    localparam logic [31:0] OFF_CAPTURE  = 32'h0000_0010;

    // CTRL bit positions
    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IRQEN    = 2;
    localparam int CTRL_PEND     = 3;

    // Packed so that the struct bit order matches the CTRL register layout
    typedef struct packed {
        logic pend;
        logic irqen;
        logic periodic;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/dev_timer_prescaler.sv
// dev_timer_prescaler
//   Divides the clock by (PRESCALE + 1) while the timer is enabled.
//   Ports:
//     iCLOCK, inRESET (async, active-low), iRESET_SYNC (sync reset)
//     en_i        : timer enable; while low the internal counter sits at 0
//     prescale_i  : terminal count; a tick is produced when pcnt == prescale_i
//     restart_i   : PRESCALE is being rewritten, restart the count from 0
//     tick_o      : one-cycle tick (combinational from the registered pcnt)
module dev_timer_prescaler (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRESET_SYNC,
    input  logic        en_i,
    input  logic [31:0] prescale_i,
    input  logic        restart_i,
    output logic        tick_o
);

    logic [31:0] pcnt_q;
    logic [31:0] pcnt_d;

    assign tick_o = en_i && (pcnt_q == prescale_i);

    always_comb begin
        pcnt_d = pcnt_q + 32'd1;
        if (!en_i || restart_i || tick_o) begin
            pcnt_d = 32'd0;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            pcnt_q <= 32'd0;
        end else if (iRESET_SYNC) begin
            pcnt_q <= 32'd0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/dev_interval_timer.sv
// dev_interval_timer
//   Memory-mapped 32-bit interval timer (one device slot of the interconnect).
//   Registers: 0x0 CTRL {PEND,IRQEN,PERIODIC,EN}, 0x4 COUNT, 0x8 COMPARE,
//   0xC PRESCALE, 0x10 CAPTURE (only when DEV_TIMER_CAPTURE_EN is defined).
//   Ports:
//     iCLOCK, inRESET (async, active-low), iRESET_SYNC (sync reset)
//     iREQ/iRW/iADDR/iDATA : one-cycle request strobe, accepted when !oBUSY
//     oBUSY                : response buffer full and sink stalled
//     oREQ/oDATA           : read response, held while iBUSY is high
//     iBUSY                : response sink stall
//     oIRQ                 : registered PEND & IRQEN; iACK clears PEND
//   Handshake: a request transfers on any cycle with iREQ=1 and oBUSY=0;
//   a response transfers on any cycle with oREQ=1 and iBUSY=0, and until then
//   oREQ/oDATA stay frozen.
module dev_interval_timer
    import dev_timer_pkg::*;
#(
    parameter logic [31:0] P_PRESCALE_RESET = 32'h0,
    parameter logic [31:0] P_COMPARE_RESET  = 32'hFFFF_FFFF
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRESET_SYNC,
    input  logic        iREQ,
    output logic        oBUSY,
    input  logic        iRW,
    input  logic [31:0] iADDR,
    input  logic [31:0] iDATA,
    output logic        oREQ,
    input  logic        iBUSY,
    output logic [31:0] oDATA,
    output logic        oIRQ,
    input  logic        iACK
);

    ctrl_t       ctrl_q, ctrl_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q;
    logic [31:0] prescale_q;
    logic        irq_q;
    logic        resp_valid_q;
    logic [31:0] resp_data_q;

    logic [31:0] reg_addr;
    logic        accept, wr, rd;
    logic        wr_ctrl, wr_count, wr_compare, wr_prescale;
    logic [31:0] rdata;
    logic        tick, match;
    logic        unused_addr_bits;

    assign reg_addr         = {iADDR[31:2], 2'b00};
    assign unused_addr_bits = ^iADDR[1:0];

    assign oBUSY  = resp_valid_q & iBUSY;
    assign accept = iREQ & ~oBUSY;
    assign wr     = accept & iRW;
    assign rd     = accept & ~iRW;

    assign wr_ctrl     = wr && (reg_addr == OFF_CTRL);
    assign wr_count    = wr && (reg_addr == OFF_COUNT);
    assign wr_compare  = wr && (reg_addr == OFF_COMPARE);
    assign wr_prescale = wr && (reg_addr == OFF_PRESCALE);

`ifdef DEV_TIMER_CAPTURE_EN
    logic [31:0] cyc_q;
    logic [31:0] capture_q;
`endif

    // Read mux sees the current (pre-write) register values
    always_comb begin
        rdata = 32'd0;
        case (reg_addr)
            OFF_CTRL:     rdata = {28'd0, ctrl_q};
            OFF_COUNT:    rdata = count_q;
            OFF_COMPARE:  rdata = compare_q;
            OFF_PRESCALE: rdata = prescale_q;
`ifdef DEV_TIMER_CAPTURE_EN
            OFF_CAPTURE:  rdata = capture_q;
`endif
            default:      rdata = 32'd0;
        endcase
    end

    dev_timer_prescaler u_prescaler (
        .iCLOCK      (iCLOCK),
        .inRESET     (inRESET),
        .iRESET_SYNC (iRESET_SYNC),
        .en_i        (ctrl_q.en),
        .prescale_i  (prescale_q),
        .restart_i   (wr_prescale),
        .tick_o      (tick)
    );

    assign match = tick && (count_q == compare_q);

    // COUNT: a bus write beats the tick; a one-shot match freezes the count
    always_comb begin
        count_d = count_q;
        if (wr_count) begin
            count_d = iDATA;
        end else if (match) begin
            count_d = ctrl_q.periodic ? 32'd0 : count_q;
        end else if (tick) begin
            count_d = count_q + 32'd1;
        end
    end

    // CTRL: clears (W1C, ACK) are applied first so a same-cycle match wins
    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_ctrl) begin
            ctrl_d.en       = iDATA[CTRL_EN];
            ctrl_d.periodic = iDATA[CTRL_PERIODIC];
            ctrl_d.irqen    = iDATA[CTRL_IRQEN];
            if (iDATA[CTRL_PEND]) begin
                ctrl_d.pend = 1'b0;
            end
        end
        if (iACK) begin
            ctrl_d.pend = 1'b0;
        end
        if (match) begin
            ctrl_d.pend = 1'b1;
            if (!ctrl_q.periodic) begin
                ctrl_d.en = 1'b0;
            end
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            ctrl_q       <= '0;
            count_q      <= 32'd0;
            compare_q    <= P_COMPARE_RESET;
            prescale_q   <= P_PRESCALE_RESET;
            irq_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
        end else if (iRESET_SYNC) begin
            ctrl_q       <= '0;
            count_q      <= 32'd0;
            compare_q    <= P_COMPARE_RESET;
            prescale_q   <= P_PRESCALE_RESET;
            irq_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
        end else begin
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
            irq_q   <= ctrl_q.pend & ctrl_q.irqen;
            if (wr_compare) begin
                compare_q <= iDATA;
            end
            if (wr_prescale) begin
                prescale_q <= iDATA;
            end
            if (rd) begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= rdata;
            end else if (!(resp_valid_q && iBUSY)) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

`ifdef DEV_TIMER_CAPTURE_EN
    // Free-running cycle stamp, sampled into CAPTURE on every match
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            cyc_q     <= 32'd0;
            capture_q <= 32'd0;
        end else if (iRESET_SYNC) begin
            cyc_q     <= 32'd0;
            capture_q <= 32'd0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (match) begin
                capture_q <= cyc_q;
            end
        end
    end
`endif

    assign oREQ  = resp_valid_q;
    assign oDATA = resp_data_q;
    assign oIRQ  = irq_q;

endmodule
